// File: rtl/mem_pkg.sv
// Shared constants for the mem_array block.
// Holds the default geometry (word width, depth, address width) and the
// encoding of the wr_rd_i operation select.
package mem_pkg;

  localparam int unsigned DefWidth     = 16;
  localparam int unsigned DefDepth     = 16;
  localparam int unsigned DefAddrWidth = 4;

  // wr_rd_i encoding
  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

endpackage

// File: rtl/intf.sv
// Signal bundle for connecting a bench to mem_array.
// Ports: clk_i, rst_i (active-low). Carries wr_data_i, addr_i, wr_rd_i,
// valid_i (toward the block) and ready_o, rd_data_o (from the block).
interface intf #(
  parameter int unsigned WIDTH      = mem_pkg::DefWidth,
  parameter int unsigned ADDR_WIDTH = mem_pkg::DefAddrWidth
) (
  input logic clk_i,
  input logic rst_i
);

  logic [WIDTH-1:0]      wr_data_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  wr_rd_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [WIDTH-1:0]      rd_data_o;

  modport dut (
    input  clk_i, rst_i, wr_data_i, addr_i, wr_rd_i, valid_i,
    output ready_o, rd_data_o
  );

  modport host (
    input  clk_i, rst_i, ready_o, rd_data_o,
    output wr_data_i, addr_i, wr_rd_i, valid_i
  );

endinterface

// File: rtl/mem_storage.sv
// Word storage array with asynchronous clear.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset (clears every word)
//   we_i       - write enable for this edge
//   waddr_i    - write address; addresses >= DEPTH match no word and are dropped
//   wdata_i    - write data
//   raddr_i    - read address (combinational read)
//   rdata_o    - word at raddr_i, or zero when raddr_i >= DEPTH
module mem_storage
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Per-word compare rather than a dynamic index: an out-of-range address
  // simply matches nothing, so the drop/zero behaviour falls out for free.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we_i && (32'(waddr_i) == i)) begin
        mem_d[i] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(raddr_i) == i) begin
        rdata_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/mem_array.sv
// Single-port word memory with a valid/ready request handshake.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   wr_data_i  - write data
//   addr_i     - word address for read or write
//   wr_rd_i    - 1 = write, 0 = read
//   valid_i    - request valid
//   ready_o    - 0 in reset, 1 from the first edge after reset onward
//   rd_data_o  - registered read data, updated only by read transfers
// ADDR_WIDTH must satisfy 2**ADDR_WIDTH >= DEPTH.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rd_data_o
);

  logic             ready_q;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             xfer;
  logic             wr_xfer;
  logic             rd_xfer;

  assign xfer    = valid_i && ready_q;
  assign wr_xfer = xfer && (wr_rd_i == WRITE);
  assign rd_xfer = xfer && (wr_rd_i == READ);

  mem_storage #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_xfer),
    .waddr_i (addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (addr_i),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_xfer) begin
      rd_data_d = mem_rdata;
    end
  end

  // ready_q goes high on the first edge out of reset and never drops again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ready_q   <= 1'b1;
      rd_data_q <= rd_data_d;
    end
  end

  assign ready_o   = ready_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mem_array.sv
module tb_mem_array;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Second instance with DEPTH < 2**ADDR_WIDTH exercises out-of-range addresses.
  logic        ready2;
  logic [15:0] rd_data2;

  intf #(.WIDTH(16), .ADDR_WIDTH(4)) u_if (.clk_i(clk), .rst_i(rst));

  mem_array #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (u_if.wr_data_i),
    .addr_i    (u_if.addr_i),
    .wr_rd_i   (u_if.wr_rd_i),
    .valid_i   (u_if.valid_i),
    .ready_o   (u_if.ready_o),
    .rd_data_o (u_if.rd_data_o)
  );

  mem_array #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4)) u_dut12 (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (u_if.wr_data_i),
    .addr_i    (u_if.addr_i),
    .wr_rd_i   (u_if.wr_rd_i),
    .valid_i   (u_if.valid_i),
    .ready_o   (ready2),
    .rd_data_o (rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic op, input logic [3:0] a, input logic [15:0] d);
    u_if.valid_i   = v;
    u_if.wr_rd_i   = op;
    u_if.addr_i    = a;
    u_if.wr_data_i = d;
  endtask

  logic [15:0] held;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(1'b0, READ, 4'd0, 16'h0000);

    // Reset then idle
    tick();
    tick();
    check("reset_ready", {15'd0, u_if.ready_o}, 16'd0);
    check("reset_rdata", u_if.rd_data_o, 16'h0000);
    rst = 1'b1;
    #1;
    check("ready_before_edge", {15'd0, u_if.ready_o}, 16'd0);
    tick();
    check("ready_after_edge", {15'd0, u_if.ready_o}, 16'd1);
    check("rdata_after_reset", u_if.rd_data_o, 16'h0000);

    // Write 0xABCD to 3, read it back
    drive(1'b1, WRITE, 4'd3, 16'hABCD);
    tick();
    check("write_keeps_rdata", u_if.rd_data_o, 16'h0000);
    drive(1'b1, READ, 4'd3, 16'h0000);
    tick();
    check("read_abcd", u_if.rd_data_o, 16'hABCD);

    // Fill 0..15 with address value, then back-to-back reads
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, WRITE, 4'(i), 16'(i));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, READ, 4'(i), 16'h0000);
      tick();
      check($sformatf("b2b_read_%0d", i), u_if.rd_data_o, 16'(i));
      check($sformatf("b2b_ready_%0d", i), {15'd0, u_if.ready_o}, 16'd1);
    end

    // Read 7, then write 0xFFFF to 7 without reading
    drive(1'b1, READ, 4'd7, 16'h0000);
    tick();
    check("read7_old", u_if.rd_data_o, 16'h0007);
    drive(1'b1, WRITE, 4'd7, 16'hFFFF);
    tick();
    check("read7_held", u_if.rd_data_o, 16'h0007);
    drive(1'b1, READ, 4'd7, 16'h0000);
    tick();
    check("read7_new", u_if.rd_data_o, 16'hFFFF);

    // Write followed immediately by read of same address
    drive(1'b1, WRITE, 4'd9, 16'h5A5A);
    tick();
    drive(1'b1, READ, 4'd9, 16'h0000);
    tick();
    check("wr_then_rd", u_if.rd_data_o, 16'h5A5A);

    // valid_i=0 with toggling inputs must change nothing
    held = u_if.rd_data_o;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i % 2 == 0) ? WRITE : READ, 4'(i * 3), 16'($urandom));
      tick();
      check($sformatf("idle_hold_%0d", i), u_if.rd_data_o, held);
    end
    drive(1'b1, READ, 4'd0, 16'h0000);
    tick();
    check("idle_mem0", u_if.rd_data_o, 16'h0000);
    drive(1'b1, READ, 4'd6, 16'h0000);
    tick();
    check("idle_mem6", u_if.rd_data_o, 16'h0006);
    drive(1'b1, READ, 4'd3, 16'h0000);
    tick();
    check("idle_mem3", u_if.rd_data_o, 16'h0003);

    // Write 0x1111 to 5, reset asynchronously with a read in flight
    drive(1'b1, WRITE, 4'd5, 16'h1111);
    tick();
    drive(1'b1, READ, 4'd5, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_rdata", u_if.rd_data_o, 16'h0000);
    check("async_rst_ready", {15'd0, u_if.ready_o}, 16'd0);
    tick();
    check("rst_read_aborted", u_if.rd_data_o, 16'h0000);
    drive(1'b0, READ, 4'd0, 16'h0000);
    rst = 1'b1;
    tick();
    check("ready_after_rst2", {15'd0, u_if.ready_o}, 16'd1);
    drive(1'b1, READ, 4'd5, 16'h0000);
    tick();
    check("post_rst_addr5", u_if.rd_data_o, 16'h0000);
    drive(1'b1, READ, 4'd3, 16'h0000);
    tick();
    check("post_rst_addr3", u_if.rd_data_o, 16'h0000);

    // Out-of-range on the DEPTH=12 instance
    drive(1'b1, WRITE, 4'd13, 16'h1234);
    tick();
    drive(1'b1, WRITE, 4'd12, 16'h9999);
    tick();
    drive(1'b1, WRITE, 4'd11, 16'h5678);
    tick();
    drive(1'b1, READ, 4'd13, 16'h0000);
    tick();
    check("oor_read13_d12", rd_data2, 16'h0000);
    check("inrange_read13_d16", u_if.rd_data_o, 16'h1234);
    drive(1'b1, READ, 4'd12, 16'h0000);
    tick();
    check("oor_read12_d12", rd_data2, 16'h0000);
    drive(1'b1, READ, 4'd11, 16'h0000);
    tick();
    check("last_word_d12", rd_data2, 16'h5678);
    drive(1'b0, READ, 4'd0, 16'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_array.md
MEM_ARRAY -- requirements
Module: mem_array

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of addressable words.
REQ-003 Parameter ADDR_WIDTH, default 4, address width in bits; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_data_i  input  WIDTH  write data.
REQ-007 addr_i  input  ADDR_WIDTH  word address for read or write.
REQ-008 wr_rd_i  input  1  operation select: 1 = write, 0 = read.
REQ-009 valid_i  input  1  request valid; qualifies wr_data_i, addr_i, wr_rd_i.
REQ-010 ready_o  output  1  block can accept a request this cycle.
REQ-011 rd_data_o  output  WIDTH  registered read data.

Function
REQ-012 Handshake: a transfer SHALL occur on a rising clk edge where valid_i=1 and ready_o=1; no other edge has any effect.
REQ-013 ready_o SHALL be 0 while rst=0 and SHALL rise on the first rising clk edge after rst deasserts, then stay at 1; the block never back-pressures.
REQ-014 Write transfer: mem[addr_i] <= wr_data_i at the transfer edge; rd_data_o is unchanged.
REQ-015 Read transfer: rd_data_o <= mem[addr_i] at the transfer edge (1-cycle latency, data valid after that edge).
REQ-016 rd_data_o SHALL hold its last value until the next read transfer or reset.
REQ-017 Write followed by a read of the same address on the next edge SHALL return the newly written data.
REQ-018 Back-to-back transfers on consecutive edges SHALL be accepted without bubbles.
REQ-019 Out-of-range address (addr_i >= DEPTH): writes are dropped; reads return all zeros.
REQ-020 valid_i=0 cycles SHALL leave the memory and rd_data_o unchanged, whatever the other inputs.
REQ-021 X/don't-care data on wr_data_i or addr_i while valid_i=0 SHALL NOT corrupt state.

Reset
REQ-022 Asserting rst (0) SHALL immediately, without waiting for clk, force rd_data_o=0, ready_o=0 and every memory word to 0.
REQ-023 Reset asserted mid-operation aborts any in-flight read, so rd_data_o=0, and discards the write on that edge.
REQ-024 After rst returns to 1, the first accepted read of any address SHALL return 0 until that address is written.

Structure
REQ-025 Package mem_pkg holds the default WIDTH, DEPTH and ADDR_WIDTH constants and the op encoding constants (WRITE=1, READ=0).
REQ-026 Interface intf (ports clk_i, rst_i) bundles wr_data_i, addr_i, wr_rd_i, valid_i, ready_o and rd_data_o for bench connection.
REQ-027 The storage array with its clear-on-reset SHALL be a single sub-module mem_storage; mem_array contains the handshake, ready and read-register logic.

Verification
REQ-028 Reset then idle: rst=0 for 2 cycles, release -> ready_o=0 during reset and 1 after first edge; rd_data_o=0.
REQ-029 Write 0xABCD to addr 3, then read addr 3 -> rd_data_o=0xABCD one cycle after the read edge.
REQ-030 Write the address value to each of addrs 0..15, then read 0..15 back-to-back -> each read returns its address, with no stalls.
REQ-031 Write 0x1111 to addr 5, then assert rst for 1 cycle, release, read addr 5 -> rd_data_o=0x0000.
REQ-032 Read addr 7 (data 0x0007), then write 0xFFFF to addr 7 with no further read -> rd_data_o stays 0x0007; a next read returns 0xFFFF.
REQ-033 Toggle addr_i, wr_data_i and wr_rd_i=1 with valid_i=0 for 10 cycles -> memory contents and rd_data_o unchanged.
